// File: rtl/ahb_uart_tx.sv
// AHB-Lite transmit-only UART: bus-written byte FIFO drained by an 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module ahb_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [15:0]   BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // Bus address/data phase tracking
  logic       dp_valid;
  logic       dp_write;
  logic [1:0] dp_addr;
  logic       addr_accept;

  assign addr_accept = HSEL & HREADY & HTRANS[1];
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= addr_accept;
      if (addr_accept) begin
        dp_write <= HWRITE;
        dp_addr  <= HADDR[3:2];
      end
    end
  end

  logic wr_data, wr_status, wr_ctrl;
  assign wr_data   = dp_valid & dp_write & (dp_addr == 2'd0);
  assign wr_status = dp_valid & dp_write & (dp_addr == 2'd1);
  assign wr_ctrl   = dp_valid & dp_write & (dp_addr == 2'd2);

  // FIFO and control registers
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, overflow;
  logic          enable, irq_en;
  logic          push, pop;

  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);
  assign push  = wr_data & ~full;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= HWDATA[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_data && full)                overflow <= 1'b1;
      else if (wr_status && HWDATA[3])   overflow <= 1'b0;
      if (wr_ctrl) begin
        enable <= HWDATA[0];
        irq_en <= HWDATA[1];
      end
    end
  end

  // Serialiser
  state_t     state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  sh, sh_n;
  logic        tx_n;
  logic        busy;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_n;
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      bit_q <= '0;
      sh    <= '0;
      o_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bit_q <= bit_n;
      sh    <= sh_n;
      o_tx  <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  end

  // o_tx is registered from the next-state values so the line changes on the transition edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_q;
    sh_n    = sh;
    pop     = 1'b0;
    tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      S_IDLE: begin
        if (enable && !empty) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr];
          cnt_n   = BAUD_LOAD;
          state_n = S_START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^mem[rd_ptr];
`endif
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_n   = BAUD_LOAD;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_n = BAUD_LOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_q + 1'b1;
            sh_n  = {1'b0, sh[7:1]};
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          cnt_n   = BAUD_LOAD;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = sh_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) o_irq <= 1'b0;
    else         o_irq <= irq_en & empty & ~busy;
  end

  // Read data
  logic [31:0] status_word;

  always_comb begin
    status_word           = '0;
    status_word[0]        = busy;
    status_word[1]        = full;
    status_word[2]        = empty;
    status_word[3]        = overflow;
    status_word[8 +: LW]  = level;
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        2'd1:    HRDATA = status_word;
        2'd2:    HRDATA = {30'b0, irq_en, enable};
        default: HRDATA = '0;
      endcase
    end
  end

  logic unused_bus_bits;
  assign unused_bus_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Self-checking bench for ahb_uart_tx: register vectors, directed frame timing
// sequences and randomized traffic against a byte-queue/frame-decoder model.
module tb_ahb_uart_tx;

  localparam int C = 4;
  localparam int D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int NBC  = NB * C;
  localparam int MAXS = 8 * NBC + 16;

  logic        i_clk, i_reset;
  logic        HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, HRESP, o_tx, o_irq;
  logic [31:0] HRDATA;

  ahb_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .o_tx(o_tx), .o_irq(o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: bytes accepted into the FIFO, pushes/pops, sticky overflow
  logic [7:0] sbq[$];
  int         pushed = 0;
  int         popped = 0;
  bit         ovf_m  = 1'b0;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int lvl;
    lvl = pushed - popped;
    s = '0;
    s[12:8] = 5'(lvl);
    s[3] = ovf_m;
    s[2] = (lvl == 0);
    s[1] = (lvl == D);
    return s;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    case (addr[3:2])
      2'd0: begin
        if (pushed - popped >= D) ovf_m = 1'b1;
        else begin
          sbq.push_back(data[7:0]);
          pushed++;
        end
      end
      2'd1: if (data[3]) ovf_m = 1'b0;
      default: ;
    endcase
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge i_clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(negedge i_clk); #1;
    model_write(addr, data);
    @(posedge i_clk); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [31:0] snap);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge i_clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge i_clk); #1;
    data = HRDATA;
    snap = exp_status();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    sbq.delete();
    pushed = 0; popped = 0; ovf_m = 1'b0;
    i_reset = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("drain_done", sbq.size(), 0);
    repeat (3) begin @(posedge i_clk); #1; end
  endtask

  // Frame decoder: every falling edge of the idle line is a pop; each bit must hold C cycles
  initial begin
    logic [NB-1:0] seen, expv;
    logic [7:0]    e;
    bit            ok, abort;
    forever begin
      @(negedge i_clk);
      if (i_reset === 1'b0 && o_tx === 1'b0) begin
        popped++;
        ok = 1'b1; abort = 1'b0; seen = '0;
        for (int bi = 0; bi < NB && !abort; bi++) begin
          for (int k = 0; k < C && !abort; k++) begin
            if (bi != 0 || k != 0) @(negedge i_clk);
            if (i_reset !== 1'b0) abort = 1'b1;
            else if (k == 0) seen[bi] = o_tx;
            else if (o_tx !== seen[bi]) ok = 1'b0;
          end
        end
        if (!abort) begin
          if (sbq.size() == 0) begin
            chk("unexpected_frame", 32'(seen), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            for (int i = 0; i < NB; i++) expv[i] = frame_bit(e, i);
            chk("frame_bits", 32'(seen), 32'(expv));
            chk("frame_bit_hold", 32'(ok), 32'd1);
          end
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[15];
    logic [31:0] rd, snap;
    logic        tx_s[MAXS];
    logic        irq_s[MAXS];
    logic        v;
    bit          stable;
    int          s, st, en, zeros;
    logic [7:0]  b;

    i_reset = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1;

    // Reset state
    do_reset();
    chk("rst_tx", o_tx, 1'b1);
    chk("rst_irq", o_irq, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hreadyout", HREADYOUT, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    bus_read(32'h4, rd, snap);
    chk("rst_status", rd, 32'h0000_0004);

    // irq lags its terms by one cycle
    bus_write(32'h8, 32'h2);
    chk("irq_lag0", o_irq, 1'b0);
    @(posedge i_clk); #1;
    chk("irq_lag1", o_irq, 1'b1);
    bus_write(32'h0, 32'h55);
    @(posedge i_clk); #1;
    chk("irq_not_empty", o_irq, 1'b0);

    // Register access vectors from reset, enable=0
    do_reset();
    vecs = '{
      '{0, 32'h4, 32'h0,         32'h0000_0004},
      '{0, 32'h8, 32'h0,         32'h0000_0000},
      '{1, 32'h8, 32'h2,         32'h0},
      '{0, 32'h8, 32'h0,         32'h0000_0002},
      '{1, 32'hC, 32'hFFFF_FFFF, 32'h0},
      '{0, 32'hC, 32'h0,         32'h0000_0000},
      '{0, 32'h0, 32'h0,         32'h0000_0000},
      '{1, 32'h0, 32'h11,        32'h0},
      '{0, 32'h4, 32'h0,         32'h0000_0100},
      '{1, 32'h0, 32'h22,        32'h0},
      '{0, 32'h4, 32'h0,         32'h0000_0200},
      '{1, 32'h4, 32'hFFFF_FFF7, 32'h0},
      '{0, 32'h4, 32'h0,         32'h0000_0200},
      '{1, 32'h8, 32'hFFFF_FFFC, 32'h0},
      '{0, 32'h8, 32'h0,         32'h0000_0000}
    };
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd, snap);
        chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Single byte 0xA5: exact line waveform
    do_reset();
    bus_write(32'h8, 32'h1);
    bus_write(32'h0, 32'hA5);
    chk("a5_pre_start", o_tx, 1'b1);
    for (int i = 0; i < NB; i++) begin
      stable = 1'b1; v = 1'bx;
      for (int k = 0; k < C; k++) begin
        @(posedge i_clk); #1;
        if (k == 0) v = o_tx;
        else if (o_tx !== v) stable = 1'b0;
      end
      chk($sformatf("a5_bit%0d", i), stable ? {31'b0, v} : 32'hDEAD, {31'b0, frame_bit(8'hA5, i)});
    end
    @(posedge i_clk); #1;
    chk("a5_idle_after", o_tx, 1'b1);
    wait_drain(10);
    bus_read(32'h4, rd, snap);
    chk("a5_status_after", rd, 32'h0000_0004);

    // Fill, overflow, clear, then drain with one idle cycle between frames
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(32'h0, 32'(8'h30 + i));
    bus_read(32'h4, rd, snap);
    chk("fill_status", rd, 32'h0000_080A);
    bus_write(32'h4, 32'h8);
    bus_read(32'h4, rd, snap);
    chk("ovf_cleared", rd, 32'h0000_0802);
    bus_write(32'h8, 32'h3);
    tx_s[0] = o_tx; irq_s[0] = o_irq;
    for (int i = 1; i < MAXS; i++) begin
      @(posedge i_clk); #1;
      tx_s[i] = o_tx; irq_s[i] = o_irq;
    end
    s = -1;
    for (int i = 0; i < MAXS; i++) if (s < 0 && tx_s[i] === 1'b0) s = i;
    chk("drain_first_start", s, 1);
    if (s < 1) s = 1;
    for (int k = 1; k < 8; k++) begin
      st = s + k * (NBC + 1);
      chk($sformatf("drain_gap%0d", k), {30'b0, tx_s[st-1], tx_s[st]}, 32'b10);
    end
    en = s + 7 * (NBC + 1) + NBC;
    chk("drain_end_tx", tx_s[en], 1'b1);
    chk("drain_end_irq", irq_s[en], 1'b0);
    chk("drain_irq_rise", irq_s[en+1], 1'b1);
    bus_read(32'h4, rd, snap);
    chk("drain_status", rd, 32'h0000_0004);
    chk("drain_queue", sbq.size(), 0);

    // Push and pop on the same edge
    do_reset();
    bus_write(32'h0, 32'h3C);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8;
    @(posedge i_clk); #1;
    HWDATA = 32'h1; HADDR = 32'h0;
    @(negedge i_clk); #1;
    model_write(32'h8, 32'h1);
    @(posedge i_clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hC9;
    @(negedge i_clk); #1;
    model_write(32'h0, 32'hC9);
    @(posedge i_clk); #1;
    chk("simul_start", o_tx, 1'b0);
    bus_read(32'h4, rd, snap);
    chk("simul_level", rd, 32'h0000_0101);
    wait_drain(3 * NBC);

    // Reset during data bit 3
    do_reset();
    bus_write(32'h8, 32'h1);
    bus_write(32'h0, 32'h08);
    bus_write(32'h0, 32'h77);
    repeat (4 * C) begin @(posedge i_clk); #1; end
    chk("mid_bit3", o_tx, 1'b1);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_mid_tx", o_tx, 1'b1);
    @(posedge i_clk); #1;
    sbq.delete(); pushed = 0; popped = 0; ovf_m = 1'b0;
    i_reset = 1'b0;
    bus_read(32'h4, rd, snap);
    chk("rst_mid_status", rd, 32'h0000_0004);
    bus_write(32'h8, 32'h1);
    zeros = 0;
    repeat (2 * NBC) begin
      @(posedge i_clk); #1;
      if (o_tx !== 1'b1) zeros++;
    end
    chk("rst_no_residual", zeros, 0);

    // Randomized traffic against the model
    do_reset();
    bus_write(32'h8, 32'h1);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          b = 8'($urandom);
          bus_write(32'h0, {24'b0, b});
        end
        2: begin
          bus_read(32'h4, rd, snap);
          chk("rand_status", rd & 32'hFFFF_FFFE, snap);
        end
        3: bus_write(32'h4, 32'h8);
        default: repeat ($urandom_range(1, 3 * NBC)) begin @(posedge i_clk); #1; end
      endcase
    end
    wait_drain(12 * (NBC + 1));
    bus_read(32'h4, rd, snap);
    chk("rand_final_status", rd & 32'hFFFF_FFFE, snap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
